// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM port between two cache requesters.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 20,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready0,
  output logic              ready1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned     CNT_W      = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BEATS);
  localparam bit              PREEMPT_EN = (MAX_BEATS != 0);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  // Next-state, round-robin choice and beat counting.
  // Preemption looks at the count including the current beat, so the port
  // yields right after its MAX_BEATS-th ready rather than one beat later.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (req0 && req1) begin
          if (last_gnt_q) begin
            state_d    = GNT0;
            last_gnt_d = 1'b0;
          end else begin
            state_d    = GNT1;
            last_gnt_d = 1'b1;
          end
        end else if (req0) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (req1) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0: begin
        if (req0 && mem_ready && (beat_cnt_q != CNT_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
        if (!req0 || (PREEMPT_EN && (beat_cnt_d == CNT_MAX) && req1)) state_d = IDLE;
      end
      GNT1: begin
        if (req1 && mem_ready && (beat_cnt_q != CNT_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
        if (!req1 || (PREEMPT_EN && (beat_cnt_d == CNT_MAX) && req0)) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // RAM port mux and per-requester handshakes, driven from the current owner.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = mem_rdata;
    unique case (state_q)
      GNT0: begin
        gnt0      = 1'b1;
        ready0    = req0 & mem_ready;
        mem_req   = req0;
        mem_rw    = rw0 & req0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      GNT1: begin
        gnt1      = 1'b1;
        ready1    = req1 & mem_ready;
        mem_req   = req1;
        mem_rw    = rw1 & req1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset; port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rw0, rw1;
  logic [9:0]  addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        ready0, ready1, gnt0, gnt1;
  logic [19:0] rdata;
  logic        mem_req, mem_rw;
  logic [9:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata;
  logic        mem_ready;

  logic [19:0] ram [0:1023];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(20), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata(rdata), .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Behavioural RAM: write on edge, combinational read.
  always @(posedge clk) if (mem_req && mem_rw) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gnt0, gnt1, ready0, ready1, mem_req, mem_rw packed as one vector
  function automatic logic [31:0] ctl();
    return {26'd0, gnt0, gnt1, ready0, ready1, mem_req, mem_rw};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_ready = 1'b1;

    // Reset held two edges with both requests high
    tick(); #1;
    chk("rst1_ctl", ctl(), 32'b000000);
    chk("rst1_addr", {22'd0, mem_addr}, 32'h0);
    tick(); rst = 1'b0; #1;
    chk("rst2_ctl", ctl(), 32'b000000);
    // First tie goes to port 0
    tick(); #1;
    chk("tie_first_gnt0", ctl(), 32'b101010);
    tick(); req0 = 1'b0; #1;
    chk("rel0_ctl", ctl(), 32'b100000);
    tick(); #1;
    chk("dead_idle", ctl(), 32'b000000);
    tick(); #1;
    chk("gnt1_after_idle", ctl(), 32'b010110);
    tick(); req1 = 1'b0; req0 = 1'b1; #1;
    chk("rel1_ctl", ctl(), 32'b010000);
    tick(); req1 = 1'b1; #1;
    chk("idle_before_tie2", ctl(), 32'b000000);
    tick(); req0 = 1'b0; req1 = 1'b0; #1;
    chk("tie2_gnt0", ctl(), 32'b100000);

    // Single requester write, two beats
    tick(); req0 = 1'b1; rw0 = 1'b1; addr0 = 10'h032; wdata0 = 20'h0ABCD; #1;
    chk("wr_idle_no_we", ctl(), 32'b000000);
    tick(); #1;
    chk("wr_beat1_ctl", ctl(), 32'b101011);
    chk("wr_beat1_addr", {22'd0, mem_addr}, 32'h032);
    chk("wr_beat1_wdata", {12'd0, mem_wdata}, 32'h0ABCD);
    tick(); #1;
    chk("wr_beat2_ctl", ctl(), 32'b101011);
    tick(); req0 = 1'b0; rw0 = 1'b0; #1;
    chk("wr_release", ctl(), 32'b100000);
    tick(); #1;
    chk("wr_ram", {12'd0, ram[10'h032]}, 32'h0ABCD);

    // Preemption: req0 reads, req1 arrives at beat 1
    req0 = 1'b1; addr0 = 10'h040; #1;
    tick(); req1 = 1'b1; addr1 = 10'h055; #1;
    chk("pre_b1", ctl(), 32'b101010);
    tick(); #1;
    chk("pre_b2", ctl(), 32'b101010);
    tick(); #1;
    chk("pre_b3", ctl(), 32'b101010);
    tick(); #1;
    chk("pre_b4", ctl(), 32'b101010);
    tick(); #1;
    chk("pre_idle", ctl(), 32'b000000);
    tick(); #1;
    chk("pre_gnt1", ctl(), 32'b010110);
    chk("pre_gnt1_addr", {22'd0, mem_addr}, 32'h055);

    // Stall during GNT1: three cycles without mem_ready
    tick(); mem_ready = 1'b0; #1;
    chk("stall1", ctl(), 32'b010010);
    chk("stall1_addr", {22'd0, mem_addr}, 32'h055);
    tick(); #1;
    chk("stall2", ctl(), 32'b010010);
    tick(); #1;
    chk("stall3", ctl(), 32'b010010);
    chk("stall3_addr", {22'd0, mem_addr}, 32'h055);
    // Three more beats complete port 1's quota of four
    tick(); mem_ready = 1'b1; #1;
    chk("post_stall_b2", ctl(), 32'b010110);
    tick(); #1;
    chk("post_stall_b3", ctl(), 32'b010110);
    tick(); #1;
    chk("post_stall_b4", ctl(), 32'b010110);
    tick(); #1;
    chk("pre1_idle", ctl(), 32'b000000);
    tick(); req1 = 1'b0; #1;
    chk("resume_b5", ctl(), 32'b101010);
    chk("resume_addr", {22'd0, mem_addr}, 32'h040);
    tick(); #1;
    chk("resume_b6", ctl(), 32'b101010);
    tick(); req0 = 1'b0; #1;
    chk("resume_release", ctl(), 32'b100000);

    // Write-enable safety: port 1 wants to write but is not requesting
    tick(); req0 = 1'b1; rw0 = 1'b0; addr0 = 10'h032;
    rw1 = 1'b1; req1 = 1'b0; addr1 = 10'h032; wdata1 = 20'h12345; #1;
    chk("safe_idle", ctl(), 32'b000000);
    tick(); #1;
    chk("safe_rd1", ctl(), 32'b101010);
    chk("safe_rdata", {12'd0, rdata}, 32'h0ABCD);
    tick(); #1;
    chk("safe_rd2", ctl(), 32'b101010);
    tick(); req0 = 1'b0; #1;
    chk("safe_release", ctl(), 32'b100000);
    tick(); #1;
    chk("safe_ram", {12'd0, ram[10'h032]}, 32'h0ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
